// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Accepts a parallel word on a valid/ready handshake and steps the registered
// TX output mux through start, data (LSB first), optional parity and stop
// selections, one bit per clk cycle. All outputs decode registered state only.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  ready,
  output logic                  busy,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // Output mux selections seen by the downstream registered mux.
  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   word_reg, word_next;
  logic                    par_en_reg, par_en_next;
  logic                    par_typ_reg, par_typ_next;
  logic                    accept;

  // A word can be taken while idle or during the stop bit, which allows
  // back-to-back frames without an idle gap on the line.
  assign ready  = (state_reg == S_IDLE) || (state_reg == S_STOP);
  assign accept = data_valid & ready;

  // State, counter and captured-frame registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      word_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      word_reg    <= word_next;
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
    end
  end

  // Next-state, bit counter and capture logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    word_next    = word_reg;
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_START;
      end
      S_START: begin
        state_next = S_DATA;
      end
      S_DATA: begin
        // Counter holds at the last bit index instead of wrapping.
        if (cnt_reg == CNT_LAST) begin
          state_next = par_en_reg ? S_PARITY : S_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PARITY: begin
        state_next = S_STOP;
      end
      S_STOP: begin
        state_next = accept ? S_START : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Frame settings are frozen at acceptance; later input changes are ignored.
    if (accept) begin
      word_next    = p_data;
      par_en_next  = par_en;
      par_typ_next = par_typ;
      cnt_next     = '0;
    end
  end

  // Mux select and busy decoded from the registered state alone.
  always_comb begin
    mux_sel = SEL_STOP;
    busy    = 1'b0;
    case (state_reg)
      S_IDLE:   begin mux_sel = SEL_STOP;   busy = 1'b0; end
      S_START:  begin mux_sel = SEL_START;  busy = 1'b1; end
      S_DATA:   begin mux_sel = SEL_DATA;   busy = 1'b1; end
      S_PARITY: begin mux_sel = SEL_PARITY; busy = 1'b1; end
      S_STOP:   begin mux_sel = SEL_STOP;   busy = 1'b1; end
      default:  begin mux_sel = SEL_STOP;   busy = 1'b0; end
    endcase
  end

  // Payload bit walks LSB first during DATA and rests on bit 0 elsewhere.
  assign ser_data = (state_reg == S_DATA) ? word_reg[cnt_reg] : word_reg[0];

  // Parity of the captured word; odd parity inverts the even result.
  assign par_bit = (^word_reg) ^ par_typ_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for the UART TX frame sequencer.
// Expected frames are built from the frame rules (start, payload LSB first,
// optional parity, stop) by a small reference model inside the bench.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         ready;
  logic         busy;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;

  int pass_cnt;
  int total_cnt;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ready      (ready),
    .busy       (busy),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference parity: count ones, odd count gives 1 for even parity.
  function automatic logic ref_parity(input logic [W-1:0] w, input logic typ);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += (w >> i) & 1;
    return logic'(ones % 2) ^ typ;
  endfunction

  // Check the idle line state (after a frame or reset).
  task automatic check_idle(input string tag);
    total_cnt++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL %s idle: mux_sel=%b busy=%b ready=%b, required 01/0/1", tag, mux_sel, busy, ready);
    end else pass_cnt++;
  endtask

  // Present a word and take it on the next edge; leaves the bench in the START cycle.
  task automatic accept_word(input logic [W-1:0] w, input logic pe, input logic pt, input string tag);
    p_data     = w;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL %s ready before accept: got %b, required 1", tag, ready);
    else pass_cnt++;
    tick();
    data_valid = 1'b0;
  endtask

  // Walk a whole frame from START to STOP against the reference model; ends in the STOP cycle.
  // With noisy set, inputs are scrambled and data_valid toggled while the block is not ready.
  task automatic check_frame(input logic [W-1:0] w, input logic pe, input logic pt,
                             input bit noisy, input string tag);
    int          n;
    logic [1:0]  exp_sel;
    logic        exp_ser;
    logic        exp_par;
    logic        exp_rdy;
    n       = 2 + W + int'(pe);
    exp_par = ref_parity(w, pt);
    for (int c = 0; c < n; c++) begin
      if (c == 0)                 exp_sel = 2'b00;
      else if (c <= W)            exp_sel = 2'b10;
      else if (c == W + 1 && pe)  exp_sel = 2'b11;
      else                        exp_sel = 2'b01;
      exp_ser = (c >= 1 && c <= W) ? w[c-1] : w[0];
      exp_rdy = (c == n - 1);
      total_cnt++;
      if (mux_sel !== exp_sel || busy !== 1'b1 || ser_data !== exp_ser ||
          par_bit !== exp_par || ready !== exp_rdy) begin
        $display("FAIL %s word=%h cycle %0d: mux_sel=%b busy=%b ser=%b par=%b ready=%b, required %b/1/%b/%b/%b",
                 tag, w, c, mux_sel, busy, ser_data, par_bit, ready, exp_sel, exp_ser, exp_par, exp_rdy);
      end else pass_cnt++;
      if (c < n - 1) begin
        if (noisy) begin
          p_data     = W'($urandom);
          par_en     = 1'($urandom);
          par_typ    = 1'($urandom);
          data_valid = 1'($urandom);
        end
        tick();
        data_valid = 1'b0;
      end
    end
    $display("frame %s word=%h par_en=%b par_typ=%b len=%0d par_bit=%b", tag, w, pe, pt, n, exp_par);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_valid = 1'b1;
    p_data     = 8'h5A;
    par_en     = 1'b1;
    par_typ    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (mux_sel !== 2'b01 || busy !== 1'b0 || ready !== 1'b1 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
        $display("FAIL reset cycle %0d: mux_sel=%b busy=%b ready=%b ser=%b par=%b, required 01/0/1/0/0",
                 i, mux_sel, busy, ready, ser_data, par_bit);
      end else pass_cnt++;
    end
    rst        = 1'b0;
    data_valid = 1'b0;
    tick();
    check_idle("post_reset");
    $display("reset checked");
  endtask

  task automatic test_basic();
    accept_word(8'hA5, 1'b0, 1'b0, "basic");
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0, "basic");
    tick();
    check_idle("basic_end");
  endtask

  task automatic test_parity();
    accept_word(8'h07, 1'b1, 1'b0, "par_even");
    check_frame(8'h07, 1'b1, 1'b0, 1'b0, "par_even");
    tick();
    check_idle("par_even_end");
    accept_word(8'h00, 1'b1, 1'b1, "par_odd");
    check_frame(8'h00, 1'b1, 1'b1, 1'b0, "par_odd");
    tick();
    check_idle("par_odd_end");
  endtask

  task automatic test_back_to_back();
    accept_word(8'h3C, 1'b0, 1'b0, "b2b_first");
    check_frame(8'h3C, 1'b0, 1'b0, 1'b0, "b2b_first");
    accept_word(8'hC3, 1'b0, 1'b0, "b2b_second");
    check_frame(8'hC3, 1'b0, 1'b0, 1'b0, "b2b_second");
    tick();
    check_idle("b2b_end");
  endtask

  task automatic test_input_noise();
    accept_word(8'h96, 1'b1, 1'b1, "noise");
    check_frame(8'h96, 1'b1, 1'b1, 1'b1, "noise");
    tick();
    check_idle("noise_end");
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] w;
    w = 8'hE9;
    accept_word(w, 1'b1, 1'b0, "midrst");
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (mux_sel !== 2'b10 || ser_data !== w[4]) begin
      $display("FAIL midrst bit4: mux_sel=%b ser=%b, required 10/%b", mux_sel, ser_data, w[4]);
    end else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || ready !== 1'b1 || ser_data !== 1'b0 || par_bit !== 1'b0) begin
      $display("FAIL midrst abort: mux_sel=%b busy=%b ready=%b ser=%b par=%b, required 01/0/1/0/0",
               mux_sel, busy, ready, ser_data, par_bit);
    end else pass_cnt++;
    tick();
    check_idle("midrst_idle");
    accept_word(8'h4B, 1'b1, 1'b1, "midrst_after");
    check_frame(8'h4B, 1'b1, 1'b1, 1'b0, "midrst_after");
    tick();
    check_idle("midrst_end");
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    logic         pe;
    logic         pt;
    bit           in_stop;
    bit           chain;
    in_stop = 1'b0;
    for (int i = 0; i < 24; i++) begin
      w     = W'($urandom);
      pe    = 1'($urandom);
      pt    = 1'($urandom);
      chain = 1'($urandom);
      if (in_stop && !chain) begin
        tick();
        check_idle("rand_gap");
      end
      accept_word(w, pe, pt, "rand");
      check_frame(w, pe, pt, 1'($urandom), "rand");
      in_stop = 1'b1;
    end
    tick();
    check_idle("rand_end");
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_input_noise();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
